regfile_bypass: RTL and testbench
=================================

Name: regfile_bypass

Overview:
- Architectural register file for the pipelined core: one write port (driven by writeback), two read ports (consumed by decode).
- Storage is an array of enabled 16-bit registers.
- A same-cycle write-to-read bypass lets decode see the value being written back, which removes the WB->ID hazard stall.
- Read ports are combinational; the write port is clocked.

Parameters:
- NUM_REGS, 8, number of architectural registers (2..16).
- WIDTH, 16, data width per register.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_REGS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- read1RegSel  input  SEL_W  register index for read port 1.
- read2RegSel  input  SEL_W  register index for read port 2.
- writeRegSel  input  SEL_W  register index for the write port.
- writeData  input  WIDTH  data to write.
- write  input  1  write enable.
- read1Data  output  WIDTH  read port 1 data, combinational.
- read2Data  output  WIDTH  read port 2 data, combinational.
- err  output  1  combinational select-range error flag.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - On a rising edge with rst=1, every register becomes 0.
  - rst dominates write; the write is dropped.
  - There is no asynchronous path; read outputs are not forced during the rst cycle.
  - From the first cycle after the reset edge, all reads return 0.
- Write:
  - On a rising edge with rst=0, write=1 and writeRegSel<NUM_REGS, reg[writeRegSel] <= writeData.
  - All other registers hold their value via enable feedback.
  - If write=0, or writeRegSel>=NUM_REGS, no register changes.
- Read (0-cycle latency):
  - readNData = reg[readNRegSel] when readNRegSel<NUM_REGS, else 0.
- Bypass:
  - When write=1, rst=0, writeRegSel<NUM_REGS and readNRegSel==writeRegSel, readNData=writeData in the same cycle.
  - The bypass applies independently to each port; both ports may bypass at once.
  - The bypass is suppressed while rst=1, so the output shows the stored value.
- No register is hardwired to 0; index 0 is an ordinary register.
- err:
  - Goes high when any of these is out of range (>=NUM_REGS): read1RegSel, read2RegSel, or writeRegSel while write=1.
  - Otherwise 0.
  - err is always 0 when NUM_REGS==2**SEL_W.
  - err is 0 while rst=1.
- Simultaneous events:
  - Read and write to the same index in one cycle returns the new data (bypass), and storage updates at the edge.
  - Two reads of the same index return identical data.
- Reset mid-operation:
  - An in-flight write in the rst cycle is lost.
  - The next cycle reads 0, even at the index that was written.

Decomposition:
- Shared package: constants REG_WIDTH=16, REG_SEL_W=3, NUM_ARCH_REGS=8, reused by decode, hazard detection and this block.
- Natural sub-module: rf_entry.
  - One WIDTH-bit register with a load enable, built from dff plus a hold-feedback mux2_1.
  - Instantiated NUM_REGS times, with per-entry enable = write & ~rst & (writeRegSel==i).
  - The reset itself goes to the dff rst pin.
- The read-select mux and bypass compare live in the top level.

Test Plan:
- Reset flush:
  - Stimulus: write 0xFFFF to all 8 regs, then assert rst for 1 cycle.
  - Required response: both ports read 0x0000 for every index on the following cycles.
- Write/readback:
  - Stimulus: write reg3=0x1234 and reg5=0xBEEF on successive cycles; then read1RegSel=3, read2RegSel=5.
  - Required response: read1Data=0x1234, read2Data=0xBEEF; all other regs still 0.
- Bypass:
  - Stimulus: reg2 holds 0x0001; in one cycle drive write=1, writeRegSel=2, writeData=0xA5A5, read1RegSel=2, read2RegSel=2.
  - Required response: both ports show 0xA5A5 in that same cycle; the next cycle with write=0 still reads 0xA5A5.
- Write disabled:
  - Stimulus: write=0, writeRegSel=4, writeData=0x7777, read1RegSel=4.
  - Required response: read1Data keeps the old value (0x0000); no change after the edge.
- Reset vs write collision:
  - Stimulus: rst=1 and write=1 to reg6 with 0x5555, read1RegSel=6.
  - Required response: no bypass (read1Data = stored value in that cycle); after the edge reg6=0x0000.
- Range error (NUM_REGS=6, SEL_W=3):
  - Stimulus: read1RegSel=7.
  - Required response: read1Data=0, err=1.
  - Stimulus: write=1 with writeRegSel=6.
  - Required response: err=1 and no register modified.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
// Shared register-file constants used by decode, hazard detection and the register file.
// selInRange keeps the select range test in one place for every unit that needs it.
package regfile_bypass_pkg;

    localparam int REG_WIDTH     = 16;
    localparam int REG_SEL_W     = 3;
    localparam int NUM_ARCH_REGS = 8;

    function automatic logic selInRange(input int unsigned sel, input int unsigned numRegs);
        return sel < numRegs;
    endfunction

endpackage

// File: rtl/regfile_bypass_rf_entry.sv
// One register-file entry: a resettable dff whose input is a hold-feedback 2:1 mux,
// so the register only loads when its enable is high.
module rf_entry
    import regfile_bypass_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] nextQ;

    always_comb begin
        nextQ = en ? d : q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= nextQ;
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// Architectural register file: one clocked write port, two combinational read ports
// with same-cycle write-to-read bypass, and a select-range error flag.
module regfile_bypass
    import regfile_bypass_pkg::*;
#(
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int WIDTH    = REG_WIDTH,
    parameter int SEL_W    = REG_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] read1RegSel,
    input  logic [SEL_W-1:0] read2RegSel,
    input  logic [SEL_W-1:0] writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic             write,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    output logic             err
);

    logic [WIDTH-1:0]    regQ [NUM_REGS];
    logic [NUM_REGS-1:0] entryEn;
    logic                writeValid;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : gEntry
            rf_entry #(.WIDTH(WIDTH)) uEntry (
                .clk (clk),
                .rst (rst),
                .en  (entryEn[i]),
                .d   (writeData),
                .q   (regQ[i])
            );
        end
    endgenerate

    always_comb begin
        entryEn = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (write && !rst && (writeRegSel == SEL_W'(i))) begin
                entryEn[i] = 1'b1;
            end
        end
    end

    // A write only counts for bypass when it would actually land in storage at this edge.
    always_comb begin
        writeValid = write && !rst && selInRange(32'(writeRegSel), NUM_REGS);
    end

    always_comb begin
        read1Data = '0;
        read2Data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (read1RegSel == SEL_W'(i)) begin
                read1Data = regQ[i];
            end
            if (read2RegSel == SEL_W'(i)) begin
                read2Data = regQ[i];
            end
        end
        if (writeValid && (read1RegSel == writeRegSel)) begin
            read1Data = writeData;
        end
        if (writeValid && (read2RegSel == writeRegSel)) begin
            read2Data = writeData;
        end
    end

    always_comb begin
        err = !rst && (!selInRange(32'(read1RegSel), NUM_REGS)
                    || !selInRange(32'(read2RegSel), NUM_REGS)
                    || (write && !selInRange(32'(writeRegSel), NUM_REGS)));
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Scoreboard bench: an 8-entry and a 6-entry register file driven with identical
// stimulus, both checked against a behavioural model of the register-file rules.
module tb_regfile_bypass;

    typedef struct {
        logic [15:0] r1A;
        logic [15:0] r2A;
        logic        errA;
        logic [15:0] r1B;
        logic [15:0] r2B;
        logic        errB;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  read1RegSel = '0;
    logic [2:0]  read2RegSel = '0;
    logic [2:0]  writeRegSel = '0;
    logic [15:0] writeData = '0;
    logic        write = 1'b0;
    logic [15:0] read1DataA, read2DataA, read1DataB, read2DataB;
    logic        errA, errB;

    logic [15:0] memA [8];
    logic [15:0] memB [8];
    exp_t        expQ [$];
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    regfile_bypass dutA (
        .clk(clk), .rst(rst),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .writeRegSel(writeRegSel), .writeData(writeData), .write(write),
        .read1Data(read1DataA), .read2Data(read2DataA), .err(errA)
    );

    regfile_bypass #(.NUM_REGS(6), .WIDTH(16), .SEL_W(3)) dutB (
        .clk(clk), .rst(rst),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .writeRegSel(writeRegSel), .writeData(writeData), .write(write),
        .read1Data(read1DataB), .read2Data(read2DataB), .err(errB)
    );

    // Reference read: bypass if a live in-range write targets this index, else storage, else 0.
    function automatic logic [15:0] refRead(input logic [15:0] m [8], input int n, input logic r,
                                            input logic w, input int ws, input logic [15:0] wd,
                                            input int sel);
        if (!r && w && ws < n && sel == ws) return wd;
        if (sel < n) return m[sel];
        return 16'h0000;
    endfunction

    function automatic logic refErr(input int n, input logic r, input logic w, input int ws,
                                    input int s1, input int s2);
        if (r) return 1'b0;
        return (s1 >= n) || (s2 >= n) || (w && ws >= n);
    endfunction

    task automatic checkOne(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic checkOutput(input exp_t e);
        checkOne({e.tag, "/A.read1"}, read1DataA, e.r1A);
        checkOne({e.tag, "/A.read2"}, read2DataA, e.r2A);
        checkOne({e.tag, "/A.err"}, {15'd0, errA}, {15'd0, e.errA});
        checkOne({e.tag, "/B.read1"}, read1DataB, e.r1B);
        checkOne({e.tag, "/B.read2"}, read2DataB, e.r2B);
        checkOne({e.tag, "/B.err"}, {15'd0, errB}, {15'd0, e.errB});
    endtask

    // One clock cycle of stimulus; expectation is queued, then the model takes the edge.
    task automatic applyStimulus(input logic r, input logic w, input int ws, input logic [15:0] wd,
                                 input int s1, input int s2, input string tag, input bit doCheck);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; write = w; writeRegSel = 3'(ws); writeData = wd;
        read1RegSel = 3'(s1); read2RegSel = 3'(s2);
        if (doCheck) begin
            e.r1A  = refRead(memA, 8, r, w, ws, wd, s1);
            e.r2A  = refRead(memA, 8, r, w, ws, wd, s2);
            e.errA = refErr(8, r, w, ws, s1, s2);
            e.r1B  = refRead(memB, 6, r, w, ws, wd, s1);
            e.r2B  = refRead(memB, 6, r, w, ws, wd, s2);
            e.errB = refErr(6, r, w, ws, s1, s2);
            e.tag  = tag;
            expQ.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            if (r) begin
                memA[i] = '0;
                memB[i] = '0;
            end else if (w && ws == i) begin
                memA[i] = wd;
                if (i < 6) memB[i] = wd;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        applyStimulus(1, 0, 0, 16'h0, 0, 0, "initReset", 0);
        applyStimulus(1, 0, 0, 16'h0, 0, 0, "resetHold", 1);
        applyStimulus(0, 0, 0, 16'h0, 0, 7, "resetState", 1);

        for (int i = 0; i < 8; i++) applyStimulus(0, 1, i, 16'hFFFF, i, (i + 1) % 8, "fillOnes", 1);
        applyStimulus(1, 0, 0, 16'h0, 3, 5, "flushCycle", 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 16'h0, i, 7 - i, "afterFlush", 1);

        applyStimulus(0, 1, 3, 16'h1234, 0, 1, "writeReg3", 1);
        applyStimulus(0, 1, 5, 16'hBEEF, 2, 4, "writeReg5", 1);
        applyStimulus(0, 0, 0, 16'h0, 3, 5, "readback35", 1);
        applyStimulus(0, 0, 0, 16'h0, 0, 6, "othersZero", 1);

        applyStimulus(0, 1, 2, 16'h0001, 1, 1, "writeReg2", 1);
        applyStimulus(0, 1, 2, 16'hA5A5, 2, 2, "bypassBoth", 1);
        applyStimulus(0, 0, 2, 16'h0, 2, 2, "afterBypass", 1);

        applyStimulus(0, 0, 4, 16'h7777, 4, 0, "writeOff", 1);
        applyStimulus(0, 0, 0, 16'h0, 4, 4, "writeOffHold", 1);

        applyStimulus(0, 1, 6, 16'h1111, 0, 0, "preload6", 1);
        applyStimulus(1, 1, 6, 16'h5555, 6, 2, "rstVsWrite", 1);
        applyStimulus(0, 0, 0, 16'h0, 6, 2, "afterRstWr", 1);

        applyStimulus(0, 1, 1, 16'h4242, 1, 1, "preload1", 1);
        applyStimulus(0, 0, 0, 16'h0, 7, 1, "rangeRead7", 1);
        applyStimulus(0, 1, 6, 16'h9999, 0, 1, "rangeWrite6", 1);
        applyStimulus(0, 0, 0, 16'h0, 6, 1, "afterWrite6", 1);
        applyStimulus(1, 0, 0, 16'h0, 7, 6, "errDuringRst", 1);

        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(0, 31) == 0), $urandom_range(0, 1),
                          $urandom_range(0, 7), 16'($urandom),
                          $urandom_range(0, 7), $urandom_range(0, 7), "random", 1);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (expQ.size() == 0) passed++;
        else $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", expQ.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
